sha256_block_sequencer: RTL and testbench

Multi-block message controller in front of the SHA-256 core (FSM, round counter, schedule, datapath).
- Accepts a stream of pre-padded 512-bit blocks over a valid/ready handshake.
- Issues one core start per block and chains the intermediate hash into the core's IV for the next block.
- Presents the final 256-bit digest on a valid/ready output.
- Sits between the bus/DMA front end and the core; it is the only driver of the core's start, block and IV inputs.

---
 rtl/sha256_pkg.sv | 20 ++
 rtl/sha256_block_sequencer_if.sv | 24 ++
 rtl/sha256_done_edge.sv | 20 ++
 rtl/sha256_block_sequencer.sv | 122 ++++++++++++
 tb/tb_sha256_block_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block sequencer slice.
// Holds the standard initial hash value, sequencer state encoding and data widths.
package sha256_pkg;

  localparam int BLK_W = 512;
  localparam int DIG_W = 256;

  localparam logic [DIG_W-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RUN,
    CHAIN,
    OUT,
    FAULT
  } seq_state_t;

endpackage

// File: rtl/sha256_block_sequencer_if.sv
// Block-in / digest-out stream bundle of the SHA-256 block sequencer.
// master drives blocks and takes digests; slave is the sequencer side.
interface sha256_block_sequencer_if;
  import sha256_pkg::*;

  logic             blk_valid;
  logic             blk_ready;
  logic [BLK_W-1:0] blk_data;
  logic             blk_last;
  logic             digest_valid;
  logic             digest_ready;
  logic [DIG_W-1:0] digest;

  modport master (
    output blk_valid, blk_data, blk_last, digest_ready,
    input  blk_ready, digest_valid, digest
  );

  modport slave (
    input  blk_valid, blk_data, blk_last, digest_ready,
    output blk_ready, digest_valid, digest
  );

endinterface

// File: rtl/sha256_done_edge.sv
// Registered rising-edge detector for the core's done signal.
// clr masks the edge so only transitions seen while a block is running count.
module sha256_done_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level && !level_q && !clr;

endmodule

// File: rtl/sha256_block_sequencer.sv
// Multi-block SHA-256 controller: one core start per block, chains the hash into the next IV.
// Define SHA256_SEQ_TIMEOUT_EN to add a core_done watchdog with a sticky seq_fault output.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sha256_block_sequencer_if.slave bus,
  output logic                 core_start,
  output logic [BLK_W-1:0]     core_block,
  output logic [DIG_W-1:0]     core_iv,
  input  logic                 core_done,
  input  logic [DIG_W-1:0]     core_hash,
  output logic                 busy,
  output logic [CNT_W-1:0]     block_count
`ifdef SHA256_SEQ_TIMEOUT_EN
  ,
  output logic                 seq_fault
`endif
);

  seq_state_t       state, state_next;
  logic             last_q;
  logic             init_q;
  logic             done_rise;
  logic             blk_accept;
  logic [DIG_W-1:0] digest_q;

  sha256_done_edge u_done_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != RUN),
    .level (core_done),
    .rise  (done_rise)
  );

  assign blk_accept = bus.blk_valid && bus.blk_ready;
  assign bus.digest = digest_q;

`ifdef SHA256_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout;

  always_ff @(posedge clk) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (state == ISSUE) tmo_cnt <= '0;
    else if (state == RUN)   tmo_cnt <= tmo_cnt + 1'b1;
  end

  // tmo_cnt+1 RUN cycles have elapsed; FAULT lands one edge later, TIMEOUT_CYCLES after core_start.
  assign timeout = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 2));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next; a missing branch would infer a latch.
    state_next = state;
    case (state)
      IDLE:  if (blk_accept) state_next = ISSUE;
      ISSUE: state_next = RUN;
      RUN: begin
        if (done_rise) state_next = CHAIN;
`ifdef SHA256_SEQ_TIMEOUT_EN
        else if (timeout) state_next = FAULT;
`endif
      end
      CHAIN: state_next = last_q ? OUT : IDLE;
      OUT:   if (bus.digest_ready) state_next = IDLE;
`ifdef SHA256_SEQ_TIMEOUT_EN
      FAULT: state_next = FAULT;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.blk_ready    = (state == IDLE) && init_q;
    core_start       = (state == ISSUE);
    bus.digest_valid = (state == OUT);
    busy             = (state != IDLE);
`ifdef SHA256_SEQ_TIMEOUT_EN
    seq_fault        = (state == FAULT);
`endif
  end

  // NOTE: the wide block/digest registers are reset only because their reset values are visible outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_block  <= '0;
      core_iv     <= SHA256_IV;
      digest_q    <= '0;
      block_count <= '0;
      last_q      <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (blk_accept) begin
        core_block <= bus.blk_data;
        last_q     <= bus.blk_last;
      end
      if (state == RUN && done_rise) begin
        core_iv     <= core_hash;
        block_count <= block_count + 1'b1;
      end
      if (state == CHAIN && last_q) digest_q <= core_iv;
      if (state == OUT && bus.digest_ready) begin
        core_iv     <= SHA256_IV;
        block_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer with a behavioural SHA-256 compression core.
// Builds with or without SHA256_SEQ_TIMEOUT_EN; the watchdog scenario runs only when it is defined.
module tb_sha256_block_sequencer;

  localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam int CORE_LAT = 6;
  localparam int TMO      = 128;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_block_sequencer_if bus ();

  logic         core_start, core_done, busy;
  logic [511:0] core_block;
  logic [255:0] core_iv, core_hash;
  logic [15:0]  block_count;
`ifdef SHA256_SEQ_TIMEOUT_EN
  logic         seq_fault;
`endif

  logic         model_done = 1'b0;
  logic [255:0] model_hash = '0;
  logic [255:0] model_cap_iv = '0;
  logic         force_en = 1'b0;
  logic         force_done = 1'b0;
  logic [255:0] force_hash = '0;
  int           start_count = 0;
  int           checks = 0;
  int           errors = 0;

  assign core_done = force_en ? force_done : model_done;
  assign core_hash = force_en ? force_hash : model_hash;

  sha256_block_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .core_start  (core_start),
    .core_block  (core_block),
    .core_iv     (core_iv),
    .core_done   (core_done),
    .core_hash   (core_hash),
    .busy        (busy),
    .block_count (block_count)
`ifdef SHA256_SEQ_TIMEOUT_EN
    ,
    .seq_fault   (seq_fault)
`endif
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    {a, b, c, d, e, f, g, h} = iv;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {iv[255:224] + a, iv[223:192] + b, iv[191:160] + c, iv[159:128] + d,
            iv[127:96] + e, iv[95:64] + f, iv[63:32] + g, iv[31:0] + h};
  endfunction

  // Behavioural core: captures block/IV at start, answers with a one-cycle done pulse.
  initial begin : core_model
    logic [511:0] blk;
    forever begin
      @(negedge clk);
      if (!force_en && core_start === 1'b1) begin
        model_cap_iv = core_iv;
        blk = core_block;
        repeat (CORE_LAT) @(negedge clk);
        model_hash = sha_compress(model_cap_iv, blk);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  always @(negedge clk) if (core_start === 1'b1) start_count++;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_block(input logic [511:0] d, input logic l);
    int n = 0;
    bus.blk_valid = 1'b1; bus.blk_data = d; bus.blk_last = l;
    while (bus.blk_ready !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n >= 300) begin errors++; $display("FAIL send_block_timeout: blk_ready never rose"); end
    tick();
    bus.blk_valid = 1'b0; bus.blk_data = '0; bus.blk_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (core_done !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n >= 300) begin errors++; $display("FAIL wait_done_timeout: core_done never seen"); end
  endtask

  task automatic wait_digest();
    int n = 0;
    while (bus.digest_valid !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n >= 300) begin errors++; $display("FAIL wait_digest_timeout: digest_valid never rose"); end
  endtask

  task automatic take_digest();
    bus.digest_ready = 1'b1;
    tick();
    bus.digest_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL reset_blk_ready: got %b exp 0", bus.blk_ready); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b exp 0", core_start); end
    checks++; if (core_block !== '0) begin errors++; $display("FAIL reset_core_block: got %h exp 0", core_block); end
    checks++; if (core_iv !== IV) begin errors++; $display("FAIL reset_core_iv: got %h exp %h", core_iv, IV); end
    checks++; if (bus.digest_valid !== 1'b0) begin errors++; $display("FAIL reset_digest_valid: got %b exp 0", bus.digest_valid); end
    checks++; if (bus.digest !== '0) begin errors++; $display("FAIL reset_digest: got %h exp 0", bus.digest); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (block_count !== 16'd0) begin errors++; $display("FAIL reset_block_count: got %0d exp 0", block_count); end
`ifdef SHA256_SEQ_TIMEOUT_EN
    checks++; if (seq_fault !== 1'b0) begin errors++; $display("FAIL reset_seq_fault: got %b exp 0", seq_fault); end
`endif
    rst_n = 1'b1;
    checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_delay: got %b exp 0", bus.blk_ready); end
    tick();
    checks++; if (bus.blk_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b exp 1", bus.blk_ready); end
  endtask

  task automatic test_single_abc();
    int s0 = start_count;
    send_block(ABC_BLK, 1'b1);
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL abc_start_latency: got %b exp 1", core_start); end
    checks++; if (model_cap_iv !== IV) begin errors++; $display("FAIL abc_first_iv: got %h exp %h", model_cap_iv, IV); end
    checks++; if (core_block !== ABC_BLK) begin errors++; $display("FAIL abc_core_block: got %h exp %h", core_block, ABC_BLK); end
    tick();
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL abc_start_width: got %b exp 0", core_start); end
    wait_done();
    tick();
    checks++; if (bus.digest_valid !== 1'b0) begin errors++; $display("FAIL abc_valid_early: got %b exp 0", bus.digest_valid); end
    tick();
    checks++; if (bus.digest_valid !== 1'b1) begin errors++; $display("FAIL abc_valid_latency: got %b exp 1", bus.digest_valid); end
    checks++; if (bus.digest !== ABC_DIG) begin errors++; $display("FAIL abc_digest: got %h exp %h", bus.digest, ABC_DIG); end
    checks++; if (block_count !== 16'd1) begin errors++; $display("FAIL abc_block_count: got %0d exp 1", block_count); end
    checks++; if (start_count - s0 !== 1) begin errors++; $display("FAIL abc_start_count: got %0d exp 1", start_count - s0); end
    take_digest();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abc_idle_after: got busy %b exp 0", busy); end
    checks++; if (block_count !== 16'd0) begin errors++; $display("FAIL abc_count_clear: got %0d exp 0", block_count); end
    checks++; if (core_iv !== IV) begin errors++; $display("FAIL abc_iv_restore: got %h exp %h", core_iv, IV); end
  endtask

  task automatic test_two_block();
    logic [255:0] h1;
    send_block(TWO_B1, 1'b0);
    wait_done();
    h1 = model_hash;
    tick();
    checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL two_chain_ready: got %b exp 0", bus.blk_ready); end
    tick();
    checks++; if (bus.blk_ready !== 1'b1) begin errors++; $display("FAIL two_ready_latency: got %b exp 1", bus.blk_ready); end
    checks++; if (block_count !== 16'd1) begin errors++; $display("FAIL two_count_mid: got %0d exp 1", block_count); end
    checks++; if (core_iv !== h1) begin errors++; $display("FAIL two_chain_iv: got %h exp %h", core_iv, h1); end
    send_block(TWO_B2, 1'b1);
    checks++; if (model_cap_iv !== h1) begin errors++; $display("FAIL two_iv_at_start: got %h exp %h", model_cap_iv, h1); end
    wait_digest();
    checks++; if (bus.digest !== TWO_DIG) begin errors++; $display("FAIL two_digest: got %h exp %h", bus.digest, TWO_DIG); end
    checks++; if (block_count !== 16'd2) begin errors++; $display("FAIL two_block_count: got %0d exp 2", block_count); end
    take_digest();
  endtask

  task automatic test_backpressure();
    send_block(ABC_BLK, 1'b1);
    wait_digest();
    bus.blk_valid = 1'b1; bus.blk_data = TWO_B1; bus.blk_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (bus.digest_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b exp 1", i, bus.digest_valid); end
      checks++; if (bus.digest !== ABC_DIG) begin errors++; $display("FAIL bp_digest[%0d]: got %h exp %h", i, bus.digest, ABC_DIG); end
      checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b exp 0", i, bus.blk_ready); end
    end
    bus.blk_valid = 1'b0; bus.blk_data = '0;
    take_digest();
    checks++; if (busy !== 1'b0 || bus.blk_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got busy %b ready %b exp 0 1", busy, bus.blk_ready); end
    send_block(ABC_BLK, 1'b1);
    wait_digest();
    checks++; if (bus.digest !== ABC_DIG) begin errors++; $display("FAIL bp_rerun_digest: got %h exp %h", bus.digest, ABC_DIG); end
    take_digest();
  endtask

  task automatic test_back_to_back();
    bus.digest_ready = 1'b1;
    send_block(ABC_BLK, 1'b1);
    wait_digest();
    checks++; if (bus.digest !== ABC_DIG) begin errors++; $display("FAIL b2b_abc_digest: got %h exp %h", bus.digest, ABC_DIG); end
    tick();
    checks++; if (bus.digest_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_same_cycle: got valid %b busy %b exp 0 0", bus.digest_valid, busy); end
    send_block(TWO_B1, 1'b0);
    send_block(TWO_B2, 1'b1);
    wait_digest();
    checks++; if (bus.digest !== TWO_DIG) begin errors++; $display("FAIL b2b_two_digest: got %h exp %h", bus.digest, TWO_DIG); end
    tick();
    bus.digest_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    send_block(TWO_B1, 1'b0);
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b exp 1", busy); end
    rst_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || bus.blk_ready !== 1'b0 || core_start !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got busy %b ready %b start %b exp 0 0 0", busy, bus.blk_ready, core_start); end
    checks++; if (core_block !== '0) begin errors++; $display("FAIL rst_mid_block: got %h exp 0", core_block); end
    checks++; if (core_iv !== IV) begin errors++; $display("FAIL rst_mid_iv: got %h exp %h", core_iv, IV); end
    checks++; if (bus.digest !== '0 || bus.digest_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_digest: got %h valid %b exp 0 0", bus.digest, bus.digest_valid); end
    checks++; if (block_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count: got %0d exp 0", block_count); end
    rst_n = 1'b1;
    repeat (CORE_LAT + 4) tick();
    checks++; if (busy !== 1'b0 || core_iv !== IV || block_count !== 16'd0) begin errors++; $display("FAIL rst_mid_stale_done: got busy %b iv %h count %0d", busy, core_iv, block_count); end
    send_block(ABC_BLK, 1'b1);
    wait_digest();
    checks++; if (bus.digest !== ABC_DIG) begin errors++; $display("FAIL rst_mid_rerun: got %h exp %h", bus.digest, ABC_DIG); end
    take_digest();
  endtask

  task automatic test_done_level();
    force_hash = sha_compress(IV, ABC_BLK);
    force_done = 1'b1;
    force_en = 1'b1;
    tick();
    send_block(ABC_BLK, 1'b1);
    repeat (5) tick();
    checks++; if (busy !== 1'b1 || bus.digest_valid !== 1'b0) begin errors++; $display("FAIL level_premature: got busy %b valid %b exp 1 0", busy, bus.digest_valid); end
    checks++; if (block_count !== 16'd0) begin errors++; $display("FAIL level_count: got %0d exp 0", block_count); end
    force_done = 1'b0;
    tick(); tick();
    force_done = 1'b1;
    wait_digest();
    checks++; if (bus.digest !== ABC_DIG) begin errors++; $display("FAIL level_digest: got %h exp %h", bus.digest, ABC_DIG); end
    force_done = 1'b0;
    force_en = 1'b0;
    take_digest();
  endtask

`ifdef SHA256_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    force_done = 1'b0;
    force_en = 1'b1;
    send_block(ABC_BLK, 1'b1);
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL tmo_start: got %b exp 1", core_start); end
    while (seq_fault !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n !== TMO) begin errors++; $display("FAIL tmo_latency: got %0d cycles exp %0d", n, TMO); end
    bus.blk_valid = 1'b1; bus.blk_data = ABC_BLK; bus.blk_last = 1'b1;
    repeat (10) tick();
    checks++; if (seq_fault !== 1'b1 || bus.blk_ready !== 1'b0) begin errors++; $display("FAIL tmo_sticky: got fault %b ready %b exp 1 0", seq_fault, bus.blk_ready); end
    bus.blk_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (seq_fault !== 1'b0) begin errors++; $display("FAIL tmo_reset: got %b exp 0", seq_fault); end
    rst_n = 1'b1;
    force_en = 1'b0;
    tick();
  endtask
`endif

  initial begin
    bus.blk_valid = 1'b0;
    bus.blk_data = '0;
    bus.blk_last = 1'b0;
    bus.digest_ready = 1'b0;
    test_reset();
    test_single_abc();
    test_two_block();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_done_level();
`ifdef SHA256_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
